// File: rtl/hps_peak_detector.sv
`default_nettype none
// hps_peak_detector: scans one frame of NUM_BINS harmonic products and reports
// the largest eligible bin (index >= MIN_BIN) one cycle after the frame's last bin.
module hps_peak_detector #(
  parameter int NUM_BINS   = 512,
  parameter int BIN_WIDTH  = 9,
  parameter int DATA_WIDTH = 96,
  parameter int MIN_BIN    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] product_in,
  input  logic                  product_valid,
  input  logic                  frame_start,
  output logic [BIN_WIDTH-1:0]  peak_bin,
  output logic [DATA_WIDTH-1:0] peak_value,
  output logic                  peak_valid,
  output logic                  busy,
  output logic                  frame_error
);

  localparam int CW = BIN_WIDTH + 1;
  localparam logic [CW-1:0] LAST_BIN  = CW'(NUM_BINS - 1);
  localparam logic [CW-1:0] MIN_BIN_C = CW'(MIN_BIN);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SCAN   = 2'd1;
  localparam logic [1:0] S_REPORT = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] run_max_q, run_max_d;
  logic [BIN_WIDTH-1:0]  run_idx_q, run_idx_d;
  logic [BIN_WIDTH-1:0]  peak_bin_q, peak_bin_d;
  logic [DATA_WIDTH-1:0] peak_value_q, peak_value_d;
  logic                  frame_error_q, frame_error_d;

  logic                  start;
  logic                  accept;
  logic                  last;
  logic                  upd;
  logic [BIN_WIDTH-1:0]  idx;

  assign start  = product_valid & frame_start;
  assign accept = (state_q == S_SCAN) & product_valid & ~frame_start;
  assign last   = accept & (cnt_q == LAST_BIN);
  assign idx    = cnt_q[BIN_WIDTH-1:0];
  // Strictly-greater compare keeps the lowest index on ties.
  assign upd    = (cnt_q >= MIN_BIN_C) & (product_in > run_max_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_SCAN;
      S_SCAN:   if (!start && last) state_d = S_REPORT;
      S_REPORT: state_d = start ? S_SCAN : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    peak_valid = (state_q == S_REPORT);
    busy       = (state_q == S_SCAN);
  end

  always_comb begin
    cnt_d         = cnt_q;
    run_max_d     = run_max_q;
    run_idx_d     = run_idx_q;
    peak_bin_d    = peak_bin_q;
    peak_value_d  = peak_value_q;
    frame_error_d = 1'b0;
    if (start) begin
      // frame_start mid-scan aborts the partial frame and restarts at bin 0.
      cnt_d         = CNT_ONE;
      run_max_d     = '0;
      run_idx_d     = '0;
      frame_error_d = (state_q == S_SCAN);
    end else if (accept) begin
      cnt_d = cnt_q + CNT_ONE;
      if (upd) begin
        run_max_d = product_in;
        run_idx_d = idx;
      end
      // Result registers load on the last-bin edge so they are valid during REPORT.
      if (last) begin
        peak_value_d = upd ? product_in : run_max_q;
        peak_bin_d   = upd ? idx : run_idx_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q         <= '0;
      run_max_q     <= '0;
      run_idx_q     <= '0;
      peak_bin_q    <= '0;
      peak_value_q  <= '0;
      frame_error_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      run_max_q     <= run_max_d;
      run_idx_q     <= run_idx_d;
      peak_bin_q    <= peak_bin_d;
      peak_value_q  <= peak_value_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign peak_bin    = peak_bin_q;
  assign peak_value  = peak_value_q;
  assign frame_error = frame_error_q;

endmodule
`default_nettype wire

// File: tb/tb_hps_peak_detector.sv
`default_nettype none
// tb_hps_peak_detector: frame-level stimulus with a scoreboard of expected peaks,
// checked against DUT outputs on the falling clock edge.
module tb_hps_peak_detector;

  localparam int NB   = 512;
  localparam int BW   = 9;
  localparam int DW   = 96;
  localparam int MINB = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] product_in = '0;
  logic          product_valid = 1'b0;
  logic          frame_start = 1'b0;
  logic [BW-1:0] peak_bin;
  logic [DW-1:0] peak_value;
  logic          peak_valid;
  logic          busy;
  logic          frame_error;

  always #5 clock = ~clock;

  hps_peak_detector #(
    .NUM_BINS   (NB),
    .BIN_WIDTH  (BW),
    .DATA_WIDTH (DW),
    .MIN_BIN    (MINB)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .product_in    (product_in),
    .product_valid (product_valid),
    .frame_start   (frame_start),
    .peak_bin      (peak_bin),
    .peak_value    (peak_value),
    .peak_valid    (peak_valid),
    .busy          (busy),
    .frame_error   (frame_error)
  );

  typedef struct {
    logic [BW-1:0] bin;
    logic [DW-1:0] val;
  } peak_t;

  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            pv_due = -1;
  int            fe_due = -1;
  logic          exp_busy = 1'b0;
  peak_t         sb[$];
  logic [DW-1:0] frame_vals [NB];
  logic [BW-1:0] hold_bin = '0;
  logic [DW-1:0] hold_val = '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (reset) begin
      hold_bin = '0;
      hold_val = '0;
    end else begin
      check("busy", {127'd0, busy}, {127'd0, exp_busy});
      if (peak_valid || pv_due == cyc)
        check("peak_valid", {127'd0, peak_valid}, {127'd0, (pv_due == cyc)});
      if (frame_error || fe_due == cyc)
        check("frame_error", {127'd0, frame_error}, {127'd0, (fe_due == cyc)});
      if (peak_valid) begin
        if (sb.size() == 0) begin
          check("orphan_peak", 128'd1, 128'd0);
        end else begin
          peak_t p;
          p = sb.pop_front();
          check("peak_bin", {119'd0, peak_bin}, {119'd0, p.bin});
          check("peak_value", {32'd0, peak_value}, {32'd0, p.val});
          hold_bin = p.bin;
          hold_val = p.val;
        end
      end else begin
        check("hold_bin", {119'd0, peak_bin}, {119'd0, hold_bin});
        check("hold_value", {32'd0, peak_value}, {32'd0, hold_val});
      end
    end
  end

  task automatic idle_cycle();
    product_valid = 1'b0;
    product_in    = {$urandom, $urandom, $urandom};
    frame_start   = 1'($urandom_range(0, 1));
    @(posedge clock);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic send_bin(input logic [DW-1:0] v, input logic fs);
    product_valid = 1'b1;
    frame_start   = fs;
    product_in    = v;
    @(posedge clock);
    #1;
    product_valid = 1'b0;
    frame_start   = 1'b0;
  endtask

  // Drives the first n bins of frame_vals; a full frame queues its expected peak.
  task automatic run_frame(input int n, input bit gaps, input bit restart);
    peak_t e;
    e.bin = '0;
    e.val = '0;
    for (int i = MINB; i < NB; i++) begin
      if (frame_vals[i] > e.val) begin
        e.val = frame_vals[i];
        e.bin = BW'(i);
      end
    end
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0)
        while ($urandom_range(0, 3) == 0) idle_cycle();
      send_bin(frame_vals[i], (i == 0));
      if (i == 0) begin
        exp_busy = 1'b1;
        if (restart) fe_due = cyc;
      end
      if (i == NB - 1) begin
        exp_busy = 1'b0;
        pv_due   = cyc;
        sb.push_back(e);
      end
    end
  endtask

  task automatic fill(input logic [DW-1:0] v);
    for (int i = 0; i < NB; i++) frame_vals[i] = v;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_peak_bin", {119'd0, peak_bin}, 128'd0);
    check("rst_peak_value", {32'd0, peak_value}, 128'd0);
    check("rst_peak_valid", {127'd0, peak_valid}, 128'd0);
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_frame_error", {127'd0, frame_error}, 128'd0);

    // Ramp, contiguous
    for (int i = 0; i < NB; i++) frame_vals[i] = DW'(i);
    run_frame(NB, 1'b0, 1'b0);
    repeat (3) idle_cycle();

    // Single spike with random gaps
    fill(DW'(5));
    frame_vals[37] = DW'(1000);
    run_frame(NB, 1'b1, 1'b0);
    repeat (3) idle_cycle();

    // DC exclusion and ties
    fill('0);
    frame_vals[0]   = {5'd0, 1'b1, 90'd0};
    frame_vals[1]   = {5'd0, 1'b1, 90'd0};
    frame_vals[100] = DW'(77);
    frame_vals[200] = DW'(77);
    run_frame(NB, 1'b1, 1'b0);
    repeat (3) idle_cycle();

    // Early restart at bin 300, then a full frame
    fill('0);
    frame_vals[10] = DW'(50);
    run_frame(300, 1'b1, 1'b0);
    fill('0);
    frame_vals[3] = DW'(9);
    run_frame(NB, 1'b1, 1'b1);
    repeat (3) idle_cycle();

    // Back-to-back: random frame followed by all-zero frame with no dead cycle
    for (int i = 0; i < NB; i++) frame_vals[i] = DW'($urandom_range(0, 65535));
    run_frame(NB, 1'b0, 1'b0);
    fill('0);
    run_frame(NB, 1'b0, 1'b0);
    repeat (3) idle_cycle();

    // Reset mid-frame at bin 250
    for (int i = 0; i < NB; i++) frame_vals[i] = DW'(i);
    run_frame(250, 1'b1, 1'b0);
    reset    = 1'b1;
    exp_busy = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_peak_bin", {119'd0, peak_bin}, 128'd0);
    check("mid_rst_peak_value", {32'd0, peak_value}, 128'd0);
    check("mid_rst_busy", {127'd0, busy}, 128'd0);
    fill(DW'(1));
    frame_vals[400] = DW'(123);
    run_frame(NB, 1'b1, 1'b0);

    repeat (5) idle_cycle();
    check("sb_drain", 128'(sb.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
